// File: rtl/keyboard_pkg.sv
// keyboard_pkg: matrix geometry, key-code type and scanner states shared with the key state register file.
package keyboard_pkg;
  localparam int KB_COLS = 8;
  localparam int KB_ROWS = 5;
  localparam int KB_CODE_W = 6;
  typedef enum logic [2:0] {INIT, IDLE, DRIVE, SAMPLE, GAP} kb_state_t;
  typedef logic [KB_CODE_W-1:0] kb_code_t;
endpackage

// File: rtl/kb_press_detect.sv
// kb_press_detect: per-column press history, lowest-row priority pick, one event per column per frame.
// KEYBOARD_DEBOUNCE_EN adds a per-key candidate bit so a press must be seen in two consecutive frames.
module kb_press_detect
  import keyboard_pkg::*;
#(
  parameter int COLS = KB_COLS,
  parameter int ROWS = KB_ROWS
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sample_i,
  input  logic [$clog2(COLS)-1:0] col_i,
  input  logic [ROWS-1:0]         rows_i,
  output logic                    key_event_o,
  output kb_code_t                key_code_o
);
  localparam int ROW_W = $clog2(ROWS);
  logic [COLS-1:0][ROWS-1:0] hist_q;
  logic [ROWS-1:0] new_rows, hit, pick;
  logic [ROW_W-1:0] row;
  assign new_rows = rows_i & ~hist_q[col_i];
`ifdef KEYBOARD_DEBOUNCE_EN
  logic [COLS-1:0][ROWS-1:0] cand_q;
  assign hit = new_rows & cand_q[col_i];
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cand_q <= '0;
    else if (sample_i) cand_q[col_i] <= new_rows & ~pick;
  end
`else
  assign hit = new_rows;
`endif
  always_comb begin
    row = '0;
    for (int i = ROWS - 1; i >= 0; i--) if (hit[i]) row = ROW_W'(i);
  end
  assign pick = |hit ? ROWS'(1) << row : '0;
  // released rows drop out of history; only the reported row is marked held
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_q      <= '0;
      key_event_o <= 1'b0;
      key_code_o  <= '0;
    end else begin
      key_event_o <= sample_i && |hit;
      if (sample_i) hist_q[col_i] <= (hist_q[col_i] & rows_i) | pick;
      if (sample_i && |hit) key_code_o <= kb_code_t'(col_i) * kb_code_t'(ROWS) + kb_code_t'(row);
    end
  end
endmodule

// File: rtl/keyboard_scanner.sv
// keyboard_scanner: one-hot column scan of the key matrix with read strobes, frame pulses and key-press events.
// Define KEYBOARD_DEBOUNCE_EN for two-frame press confirmation.
module keyboard_scanner
  import keyboard_pkg::*;
#(
  parameter int COLS          = KB_COLS,
  parameter int ROWS          = KB_ROWS,
  parameter int SETTLE_CYCLES = 4,
  parameter int SCAN_GAP      = 16
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            scanEn,
  input  logic [6:0]      kbRow,
  output logic [COLS-1:0] kbCol,
  output logic            read,
  output logic            write,
  output logic            clear,
  output logic            frameDone,
  output logic            keyEvent,
  output kb_code_t        keyCode
);
  localparam int COL_W   = $clog2(COLS);
  localparam int CNT_MAX = SETTLE_CYCLES > SCAN_GAP ? SETTLE_CYCLES : SCAN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  kb_state_t state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic clear_q, frame_done_q, last_col, unused_rows;
  assign unused_rows = ^kbRow[6:ROWS];
  assign last_col    = col_q == COL_W'(COLS - 1);
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = '0;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        col_d = '0;
        if (scanEn) state_d = DRIVE;
      end
      DRIVE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        col_d   = (last_col || !scanEn) ? '0 : col_q + 1'b1;
        state_d = (last_col && SCAN_GAP > 0) ? GAP : (scanEn ? DRIVE : IDLE);
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCAN_GAP - 1)) begin
          state_d = scanEn ? DRIVE : IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= INIT;
      col_q        <= '0;
      cnt_q        <= '0;
      clear_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      clear_q      <= state_q == INIT;
      frame_done_q <= state_q == SAMPLE && last_col;
    end
  end
  assign kbCol     = (state_q == DRIVE || state_q == SAMPLE) ? COLS'(1) << col_q : '0;
  assign read      = state_q == SAMPLE;
  assign write     = 1'b0;
  assign clear     = clear_q;
  assign frameDone = frame_done_q;
  kb_press_detect #(.COLS(COLS), .ROWS(ROWS)) u_detect (
    .clk_i       (Clk),
    .rst_ni      (Rst_n),
    .sample_i    (read),
    .col_i       (col_q),
    .rows_i      (kbRow[ROWS-1:0]),
    .key_event_o (keyEvent),
    .key_code_o  (keyCode)
  );
endmodule
